// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a single-port, 1-cycle-latency SRAM between the
// instruction-fetch port and the load/store data port. Data has fixed
// priority; a streak counter bounds fetch starvation. Also provides run
// control: enable=0 stops new grants and halted reports when drained.
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STREAK_MAX = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  output logic                      halted,
  input  logic                      instr_req,
  input  logic [ADDR_WIDTH-1:0]     instr_addr,
  output logic                      instr_gnt,
  output logic                      instr_rvalid,
  output logic [DATA_WIDTH-1:0]     instr_rdata,
  input  logic                      data_req,
  input  logic                      data_we,
  input  logic [DATA_WIDTH/8-1:0]   data_be,
  input  logic [ADDR_WIDTH-1:0]     data_addr,
  input  logic [DATA_WIDTH-1:0]     data_wdata,
  output logic                      data_gnt,
  output logic                      data_rvalid,
  output logic [DATA_WIDTH-1:0]     data_rdata,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [DATA_WIDTH/8-1:0]   mem_be,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  input  logic [DATA_WIDTH-1:0]     mem_rdata
);

  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned SW       = $clog2(STREAK_MAX + 1);
  localparam logic [SW-1:0] STREAK_CAP = SW'(STREAK_MAX);

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_INSTR = 2'd1,
    OWN_DATA  = 2'd2
  } owner_t;

  owner_t        owner_q;
  logic [SW-1:0] streak_q;
  logic          grant_ok;
  logic          fetch_starved;

  assign grant_ok      = rst_n & enable;
  assign fetch_starved = instr_req & (streak_q == STREAK_CAP);

  // Same-cycle winner selection: data first unless fetch has waited too long
  always_comb begin
    instr_gnt = 1'b0;
    data_gnt  = 1'b0;
    if (grant_ok) begin
      if (data_req && !fetch_starved) begin
        data_gnt = 1'b1;
      end else if (instr_req) begin
        instr_gnt = 1'b1;
      end
    end
  end

  // Steer the winning port's command onto the memory interface
  always_comb begin
    mem_req   = instr_gnt | data_gnt;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (data_gnt) begin
      mem_we    = data_we;
      mem_be    = data_be;
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
    end else if (instr_gnt) begin
      mem_be    = {BE_WIDTH{1'b1}};
      mem_addr  = instr_addr;
    end
  end

  // Response routing: the previous cycle's owner gets rvalid
  always_comb begin
    instr_rvalid = rst_n && (owner_q == OWN_INSTR);
    data_rvalid  = rst_n && (owner_q == OWN_DATA);
    instr_rdata  = mem_rdata;
    data_rdata   = mem_rdata;
    halted       = !enable && (owner_q == OWN_NONE);
  end

  // Owner and starvation-streak state; streak frozen while paused
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner_q  <= OWN_NONE;
      streak_q <= '0;
    end else begin
      if (data_gnt) begin
        owner_q <= OWN_DATA;
      end else if (instr_gnt) begin
        owner_q <= OWN_INSTR;
      end else begin
        owner_q <= OWN_NONE;
      end
      if (enable) begin
        if (instr_gnt) begin
          streak_q <= '0;
        end else if (!instr_req) begin
          streak_q <= '0;
        end else if (data_gnt && (streak_q != STREAK_CAP)) begin
          streak_q <= SW'(streak_q + SW'(1));
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: per-scenario tasks check grants and
// memory drive inline; a response scoreboard checks rvalid/rdata a cycle later.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        halted;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic        instr_gnt;
  logic        instr_rvalid;
  logic [31:0] instr_rdata;
  logic        data_req;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_gnt;
  logic        data_rvalid;
  logic [31:0] data_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    bit          is_instr;
    bit          chk;
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t sb[$];

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STREAK_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .halted(halted),
    .instr_req(instr_req), .instr_addr(instr_addr), .instr_gnt(instr_gnt),
    .instr_rvalid(instr_rvalid), .instr_rdata(instr_rdata),
    .data_req(data_req), .data_we(data_we), .data_be(data_be),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_gnt(data_gnt),
    .data_rvalid(data_rvalid), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return (a ^ 32'hA5A50000) + 32'h11;
  endfunction

  // SRAM model: read data appears the cycle after the request
  always @(posedge clk) mem_rdata <= (mem_req && !mem_we) ? mem_val(mem_addr) : 32'h0;

  // Response scoreboard: compare rvalid/rdata against what was owed this cycle
  always @(negedge clk) begin
    exp_t e;
    logic [1:0]  exp_v;
    logic [31:0] act_d;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      exp_v = e.is_instr ? 2'b10 : 2'b01;
      checks++;
      if ({instr_rvalid, data_rvalid} !== exp_v) begin
        errors++;
        $display("FAIL rvalid cyc=%0d got=%b exp=%b", cyc, {instr_rvalid, data_rvalid}, exp_v);
      end
      if (e.chk) begin
        act_d = e.is_instr ? instr_rdata : data_rdata;
        checks++;
        if (act_d !== e.data) begin
          errors++;
          $display("FAIL rdata cyc=%0d got=%h exp=%h", cyc, act_d, e.data);
        end
      end
    end else begin
      checks++;
      if ({instr_rvalid, data_rvalid} !== 2'b00) begin
        errors++;
        $display("FAIL spurious_rvalid cyc=%0d got=%b exp=00", cyc, {instr_rvalid, data_rvalid});
      end
    end
  end

  task automatic push_exp(input bit is_instr, input bit chk, input logic [31:0] d);
    exp_t e;
    e.is_instr = is_instr;
    e.chk      = chk;
    e.data     = d;
    e.due      = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic step_begin();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic req, input logic [31:0] addr);
    instr_req  = req;
    instr_addr = addr;
  endtask

  task automatic set_data(input logic req, input logic we, input logic [3:0] be,
                          input logic [31:0] addr, input logic [31:0] wd);
    data_req   = req;
    data_we    = we;
    data_be    = be;
    data_addr  = addr;
    data_wdata = wd;
  endtask

  // Both ports held high from reset release: D,D,D,D,I repeating
  task automatic test_reset();
    rst_n = 1'b0;
    enable = 1'b1;
    set_instr(1'b1, 32'h500);
    set_data(1'b1, 1'b0, 4'hF, 32'h600, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step_begin();
      @(negedge clk);
      checks++;
      if ({instr_gnt, data_gnt, mem_req} !== 3'b000) begin
        errors++;
        $display("FAIL reset_quiet got=%b exp=000", {instr_gnt, data_gnt, mem_req});
      end
    end
    step_begin();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) step_begin();
      @(negedge clk);
      checks++;
      if ({instr_gnt, data_gnt} !== ((k == 4) ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL reset_release_pattern k=%0d got=%b exp=%b", k, {instr_gnt, data_gnt},
                 (k == 4) ? 2'b10 : 2'b01);
      end
      if (k == 4) push_exp(1'b1, 1'b1, mem_val(32'h500));
      else        push_exp(1'b0, 1'b1, mem_val(32'h600));
    end
  endtask

  // Single fetch read of 0x100
  task automatic test_instr_read();
    step_begin();
    set_instr(1'b0, 32'h0);
    set_data(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    step_begin();
    set_instr(1'b1, 32'h100);
    @(negedge clk);
    checks++;
    if ({instr_gnt, data_gnt, mem_req, mem_we, mem_be} !== 8'b1010_1111 || mem_addr !== 32'h100) begin
      errors++;
      $display("FAIL instr_read_cmd got=%b addr=%h exp=10101111 addr=00000100",
               {instr_gnt, data_gnt, mem_req, mem_we, mem_be}, mem_addr);
    end
    push_exp(1'b1, 1'b1, 32'hDEADBEEF);
    step_begin();
    set_instr(1'b0, 32'h0);
    @(negedge clk);
    checks++;
    if ({mem_req, mem_be, mem_addr} !== 37'h0) begin
      errors++;
      $display("FAIL idle_mem_drive got req=%b be=%h addr=%h exp=0", mem_req, mem_be, mem_addr);
    end
  endtask

  // Sustained contention starting from a cleared streak
  task automatic test_starvation();
    step_begin();
    set_instr(1'b1, 32'h700);
    set_data(1'b1, 1'b0, 4'hF, 32'h800, 32'h0);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) step_begin();
      @(negedge clk);
      checks++;
      if ({instr_gnt, data_gnt} !== ((k % 5 == 4) ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL starvation k=%0d got=%b exp=%b", k, {instr_gnt, data_gnt},
                 (k % 5 == 4) ? 2'b10 : 2'b01);
      end
      if (k % 5 == 4) push_exp(1'b1, 1'b1, mem_val(32'h700));
      else            push_exp(1'b0, 1'b1, mem_val(32'h800));
    end
    step_begin();
    set_instr(1'b0, 32'h0);
    set_data(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
  endtask

  // Partial-word store passes straight through to memory
  task automatic test_store();
    step_begin();
    set_data(1'b1, 1'b1, 4'b0011, 32'h2000, 32'h12345678);
    @(negedge clk);
    checks++;
    if ({data_gnt, instr_gnt, mem_req, mem_we, mem_be} !== 8'b1011_0011 ||
        mem_addr !== 32'h2000 || mem_wdata !== 32'h12345678) begin
      errors++;
      $display("FAIL store_cmd got=%b addr=%h wd=%h exp=10110011 addr=00002000 wd=12345678",
               {data_gnt, instr_gnt, mem_req, mem_we, mem_be}, mem_addr, mem_wdata);
    end
    push_exp(1'b0, 1'b0, 32'h0);
    step_begin();
    set_data(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
  endtask

  // Pause drains the owed response, freezes the streak, then resumes
  task automatic test_pause();
    step_begin();
    set_instr(1'b1, 32'h900);
    set_data(1'b1, 1'b0, 4'hF, 32'hA00, 32'h0);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) step_begin();
      @(negedge clk);
      checks++;
      if ({instr_gnt, data_gnt} !== 2'b01) begin
        errors++;
        $display("FAIL pause_prefill k=%0d got=%b exp=01", k, {instr_gnt, data_gnt});
      end
      push_exp(1'b0, 1'b1, mem_val(32'hA00));
    end
    for (int k = 0; k < 3; k++) begin
      step_begin();
      enable = 1'b0;
      set_instr(1'b0, 32'h0);
      @(negedge clk);
      checks++;
      if ({instr_gnt, data_gnt, mem_req, halted} !== {3'b000, (k != 0)}) begin
        errors++;
        $display("FAIL paused k=%0d got=%b exp=%b", k, {instr_gnt, data_gnt, mem_req, halted},
                 {3'b000, (k != 0)});
      end
    end
    step_begin();
    enable = 1'b1;
    set_instr(1'b1, 32'h900);
    @(negedge clk);
    checks++;
    if ({instr_gnt, data_gnt, halted} !== 3'b010) begin
      errors++;
      $display("FAIL resume_first got=%b exp=010", {instr_gnt, data_gnt, halted});
    end
    push_exp(1'b0, 1'b1, mem_val(32'hA00));
    step_begin();
    @(negedge clk);
    checks++;
    if ({instr_gnt, data_gnt} !== 2'b10) begin
      errors++;
      $display("FAIL resume_streak_kept got=%b exp=10", {instr_gnt, data_gnt});
    end
    push_exp(1'b1, 1'b1, mem_val(32'h900));
    step_begin();
    set_instr(1'b0, 32'h0);
    set_data(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    step_begin();
    enable = 1'b0;
    @(negedge clk);
    checks++;
    if (halted !== 1'b1) begin
      errors++;
      $display("FAIL halted_same_cycle got=%b exp=1", halted);
    end
    step_begin();
    enable = 1'b1;
    @(negedge clk);
  endtask

  // Alternating single-port requests granted every cycle
  task automatic test_back_to_back();
    for (int k = 0; k < 6; k++) begin
      step_begin();
      if (k % 2 == 0) begin
        set_instr(1'b1, 32'h1000 + 32'(k));
        set_data(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      end else begin
        set_instr(1'b0, 32'h0);
        set_data(1'b1, 1'b0, 4'hF, 32'h3000 + 32'(k), 32'h0);
      end
      @(negedge clk);
      checks++;
      if ({instr_gnt, data_gnt} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL b2b k=%0d got=%b exp=%b", k, {instr_gnt, data_gnt},
                 (k % 2 == 0) ? 2'b10 : 2'b01);
      end
      if (k % 2 == 0) push_exp(1'b1, 1'b1, mem_val(32'h1000 + 32'(k)));
      else            push_exp(1'b0, 1'b1, mem_val(32'h3000 + 32'(k)));
    end
    step_begin();
    set_data(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
  endtask

  // Reset right after a fetch grant drops the owed response
  task automatic test_reset_mid();
    step_begin();
    set_instr(1'b1, 32'h300);
    @(negedge clk);
    checks++;
    if (instr_gnt !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_grant got=%b exp=1", instr_gnt);
    end
    step_begin();
    rst_n = 1'b0;
    set_instr(1'b0, 32'h0);
    @(negedge clk);
    checks++;
    if (instr_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_rvalid got=%b exp=0", instr_rvalid);
    end
    step_begin();
    rst_n = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    checks++;
    if ({instr_rvalid, data_rvalid, halted} !== 3'b001) begin
      errors++;
      $display("FAIL reset_mid_after got=%b exp=001", {instr_rvalid, data_rvalid, halted});
    end
    step_begin();
    enable = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_instr_read();
    test_starvation();
    test_store();
    test_pause();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drained got=%0d exp=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
